// File: rtl/t05_sram_arbiter.sv
// t05_sram_arbiter: four-requester round-robin arbiter driving a single SRAM bus window
//   ports: clk, rst (async active-high); req/req_we/req_addr/req_wdata per-requester inputs;
//   gnt/ack/rdata/timeout_err requester outputs; wr_en/r_en/select/addr/data_i bus outputs;
//   busy_o/data_o bus inputs
module t05_sram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h33000000,
  parameter logic [7:0]  MAX_WAIT  = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [3:0]   req_we,
  input  logic [43:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic [3:0]   gnt,
  output logic [3:0]   ack,
  output logic [31:0]  rdata,
  output logic         timeout_err,
  output logic         wr_en,
  output logic         r_en,
  output logic [3:0]   select,
  output logic [31:0]  addr,
  output logic [31:0]  data_i,
  input  logic         busy_o,
  input  logic [31:0]  data_o
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state, last_gnt, win;
  logic       we_l, busy_last;
  logic [7:0] cnt;
  assign select = 4'b1111;
  // closest requester after last_gnt wins; last_gnt itself is checked last
  always_comb begin
    win = last_gnt;
    for (int k = 3; k >= 0; k--)
      if (req[last_gnt + 2'(k + 1)]) win = last_gnt + 2'(k + 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= 2'd3;
      gnt         <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      wr_en       <= 1'b0;
      r_en        <= 1'b0;
      addr        <= '0;
      data_i      <= '0;
      rdata       <= '0;
      we_l        <= 1'b0;
      cnt         <= '0;
      busy_last   <= 1'b0;
    end else begin
      // busy history only accumulates inside WAIT, so edges elsewhere are ignored
      busy_last <= (state == WAIT) & busy_o;
      case (state)
        IDLE: if (|req) begin
          gnt      <= 4'b0001 << win;
          last_gnt <= win;
          we_l     <= req_we[win];
          addr     <= BASE_ADDR + {19'b0, req_addr[11*win +: 11], 2'b00};
          data_i   <= req_we[win] ? req_wdata[32*win +: 32] : 32'b0;
          wr_en    <= req_we[win];
          r_en     <= ~req_we[win];
          cnt      <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          wr_en <= 1'b0;
          r_en  <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (busy_last & ~busy_o) begin
          if (!we_l) rdata <= data_o;
          ack   <= gnt;
          state <= DONE;
        end else if (cnt == MAX_WAIT - 8'd1) begin
          ack         <= gnt;
          timeout_err <= 1'b1;
          state       <= DONE;
        end else cnt <= cnt + 8'd1;
        DONE: begin
          ack         <= '0;
          timeout_err <= 1'b0;
          gnt         <= '0;
          addr        <= '0;
          data_i      <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_t05_sram_arbiter.sv
// tb_t05_sram_arbiter: directed scoreboard bench for t05_sram_arbiter
module tb_t05_sram_arbiter;
  logic         clk = 1'b0, rst = 1'b1;
  logic [3:0]   req = '0, req_we = '0;
  logic [43:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [3:0]   gnt, ack, select;
  logic [31:0]  rdata, addr, data_i;
  logic [31:0]  data_o = '0;
  logic         timeout_err, wr_en, r_en;
  logic         busy_o = 1'b0;

  localparam logic [31:0] BASE = 32'h33000000;
  localparam int MW = 255;

  typedef struct {logic [3:0] g; logic we; logic [31:0] a; logic [31:0] d;} iss_t;
  typedef struct {logic [3:0] g; logic to; logic [31:0] rd; int lat;} ack_t;
  iss_t iss_q[$];
  ack_t ack_q[$];
  logic [31:0] bus_dq[$];
  int checks = 0, errors = 0, cyc = 0, t_iss = 0, bus_n = 0;
  logic [31:0] rd_model = '0;

  t05_sram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .timeout_err(timeout_err), .wr_en(wr_en), .r_en(r_en), .select(select),
    .addr(addr), .data_i(data_i), .busy_o(busy_o), .data_o(data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // bus model: on a strobe, hold busy for bus_n cycles, then drop it with the next data word
  initial forever begin
    @(negedge clk);
    if (!rst && (wr_en | r_en) && bus_n > 0) begin
      busy_o = 1'b1;
      repeat (bus_n) @(negedge clk);
      busy_o = 1'b0;
      data_o = bus_dq.size() > 0 ? bus_dq.pop_front() : 32'h0;
    end
  end

  // monitor: strobe cycles and ack pulses are scored against the queues
  always @(negedge clk) begin
    iss_t x;
    ack_t y;
    if (!rst) begin
      if (|gnt) chk("gnt_onehot", $onehot(gnt), 1'b1);
      if (wr_en | r_en) begin
        t_iss = cyc;
        if (iss_q.size() == 0) chk("unexpected_strobe", {wr_en, r_en}, 2'b00);
        else begin
          x = iss_q.pop_front();
          chk("iss_gnt", gnt, x.g);
          chk("wr_en", wr_en, x.we);
          chk("r_en", r_en, !x.we);
          chk("addr", addr, x.a);
          chk("data_i", data_i, x.d);
        end
      end
      if (|ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", ack, 4'b0);
        else begin
          y = ack_q.pop_front();
          chk("ack", ack, y.g);
          chk("timeout_err", timeout_err, y.to);
          chk("rdata", rdata, y.rd);
          chk("latency", cyc - t_iss, y.lat);
        end
      end
    end
  end

  task automatic expect_txn(input int i, input logic we, input logic [10:0] off,
                            input logic [31:0] wd, input int n, input logic [31:0] dv,
                            input bit has_ack);
    iss_t x;
    ack_t y;
    req_addr[11*i +: 11] = off;
    req_wdata[32*i +: 32] = wd;
    req_we[i] = we;
    x.g = 4'(1 << i);
    x.we = we;
    x.a = BASE + {19'b0, off, 2'b00};
    x.d = we ? wd : 32'h0;
    iss_q.push_back(x);
    if (n >= 2) bus_dq.push_back(dv);
    if (!we && n >= 2) rd_model = dv;
    if (has_ack) begin
      y.g = x.g;
      y.to = n < 2;
      y.rd = rd_model;
      y.lat = n < 2 ? MW + 1 : n + 1;
      ack_q.push_back(y);
    end
  endtask

  task automatic run(input logic [3:0] r, input int n, input bit drop);
    int t;
    t = 0;
    bus_n = n;
    req = r;
    do begin
      @(negedge clk);
      t++;
      if (drop && t == 4) begin
        chk("gnt_at_drop", gnt, 4'b0001);
        req = '0;
      end
    end while (!(|ack) && t < 600);
    chk("ack_arrived", |ack, 1'b1);
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_ack", ack, 4'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_r_en", r_en, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_data_i", data_i, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_select", select, 4'b1111);
  endtask

  initial begin
    int k, t;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_gnt", gnt, 4'b0);
    chk("idle_addr", addr, 32'h0);
    // single read, requester 0
    expect_txn(0, 1'b0, 11'd5, 32'h0, 3, 32'hDEADBEEF, 1'b1);
    run(4'b0001, 3, 1'b0);
    chk("read_rdata", rdata, 32'hDEADBEEF);
    // single write, requester 2; bus data must not reach rdata
    expect_txn(2, 1'b1, 11'h409, 32'h12345678, 2, 32'h0BADF00D, 1'b1);
    run(4'b0100, 2, 1'b0);
    chk("write_rdata_kept", rdata, 32'hDEADBEEF);
    // reset in IDLE so contention starts from requester 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_model = '0;
    // contention: all four held high, grant order 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      expect_txn(i % 4, 1'b0, 11'(11'h100 * (i % 4) + 3), 32'h0, 2, 32'hA5000000 + i, 1'b1);
    bus_n = 2;
    req = 4'b1111;
    k = 0;
    t = 0;
    while (k < 5 && t < 3000) begin
      @(negedge clk);
      t++;
      if (|ack) k++;
    end
    chk("contention_acks", k, 5);
    req = '0;
    repeat (2) @(negedge clk);
    // timeout on requester 1: busy never rises
    expect_txn(1, 1'b0, 11'h7ff, 32'h0, 0, 32'h0, 1'b1);
    run(4'b0010, 0, 1'b0);
    chk("timeout_rdata_kept", rdata, 32'hA5000004);
    expect_txn(2, 1'b0, 11'h22, 32'h0, 4, 32'hCAFEF00D, 1'b1);
    run(4'b0100, 4, 1'b0);
    // reset while requester 3 sits in WAIT
    expect_txn(3, 1'b0, 11'h3, 32'h0, 0, 32'h0, 1'b0);
    bus_n = 0;
    req = 4'b1000;
    repeat (8) @(negedge clk);
    chk("gnt3_in_wait", gnt, 4'b1000);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    rd_model = '0;
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    expect_txn(0, 1'b0, 11'h11, 32'h0, 2, 32'h5555AAAA, 1'b1);
    run(4'b1001, 2, 1'b0);
    // early drop of req[0] during WAIT still completes
    expect_txn(0, 1'b0, 11'h12, 32'h0, 6, 32'h01234567, 1'b1);
    run(4'b0001, 6, 1'b1);
    chk("iss_left", iss_q.size(), 0);
    chk("ack_left", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
